// File: rtl/pc_fetch.sv
// Instruction fetch stage: program counter, IF/ID pipeline register and a
// BOOT/RUN/HALT sequencer that stops fetching on EBREAK until redirected.
module pc_fetch #(
   parameter logic [9:0]  RESET_PC = 10'h000,
   parameter logic [31:0] NOP_INSN = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [9:0]  redirect_pc,
   input  logic [31:0] insn_in,
   output logic [9:0]  pc_out,
   output logic [31:0] if_id_insn,
   output logic [9:0]  if_id_pc,
   output logic        if_id_valid,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam logic [31:0] EBREAK_INSN = 32'h00100073;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [9:0]  pc_reg, pc_next;
   logic [31:0] insn_reg, insn_next;
   logic [9:0]  ifpc_reg, ifpc_next;
   logic        valid_reg, valid_next;
   logic        halted_reg, halted_next;
   logic [31:0] count_reg, count_next;

   logic [9:0]  pc_seq;
   logic [9:0]  pc_target;

   // The 10-bit adder wraps naturally: 1020 + 4 -> 0.
   assign pc_seq    = pc_reg + 10'd4;
   assign pc_target = {redirect_pc[9:2], 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= ST_BOOT;
         pc_reg     <= RESET_PC;
         insn_reg   <= NOP_INSN;
         ifpc_reg   <= 10'd0;
         valid_reg  <= 1'b0;
         halted_reg <= 1'b0;
         count_reg  <= 32'd0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         insn_reg   <= insn_next;
         ifpc_reg   <= ifpc_next;
         valid_reg  <= valid_next;
         halted_reg <= halted_next;
         count_reg  <= count_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      insn_next  = insn_reg;
      ifpc_next  = ifpc_reg;
      valid_next = valid_reg;
      count_next = count_reg;

      case (state_reg)
         ST_BOOT: begin
            if (redirect) begin
               pc_next = pc_target;
            end else begin
               pc_next = RESET_PC;
            end
            insn_next  = NOP_INSN;
            ifpc_next  = 10'd0;
            valid_next = 1'b0;
            state_next = ST_RUN;
         end

         ST_RUN: begin
            if (redirect) begin
               pc_next    = pc_target;
               insn_next  = NOP_INSN;
               ifpc_next  = 10'd0;
               valid_next = 1'b0;
            end else if (!stall) begin
               pc_next    = pc_seq;
               insn_next  = insn_in;
               ifpc_next  = pc_reg;
               valid_next = 1'b1;
               count_next = count_reg + 32'd1;
               if (insn_in == EBREAK_INSN) begin
                  state_next = ST_HALT;
               end
            end
         end

         ST_HALT: begin
            // Stall is irrelevant here; only a redirect restarts fetch.
            insn_next  = NOP_INSN;
            ifpc_next  = 10'd0;
            valid_next = 1'b0;
            if (redirect) begin
               pc_next    = pc_target;
               state_next = ST_RUN;
            end
         end

         default: begin
            state_next = ST_BOOT;
            pc_next    = RESET_PC;
            insn_next  = NOP_INSN;
            ifpc_next  = 10'd0;
            valid_next = 1'b0;
         end
      endcase
   end

   // halted is registered alongside the state so it always equals state == HALT.
   assign halted_next = (state_next == ST_HALT);

   assign pc_out      = pc_reg;
   assign if_id_insn  = insn_reg;
   assign if_id_pc    = ifpc_reg;
   assign if_id_valid = valid_reg;
   assign halted      = halted_reg;
   assign fetch_count = count_reg;

endmodule
